hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline control generator. Drives the 2-bit enable codes consumed by the IF/ID and ID/EX pipeline
//  registers, plus the PC write enable. Detects load-use hazards, taken-branch flushes and data-memory
//  busy freezes. Sits beside the decode stage; its outputs feed each stage register's enable port.
//  Enable code (shared with stage registers): 2'b01 PASS, 2'b00 BUBBLE (clear; count still loads), 2'b10 HOLD.
// PARAMETERS
//  LOAD_STALL_CYC  1   bubble cycles inserted per load-use hazard (>=1)
//  FLUSH_CYC       1   bubble cycles inserted per taken branch (>=1)
//  CNT_W           32  width of saturating performance counters
// PORTS
//  cpu_clk       in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high
//  rs1_id        in   5      decode-stage source register 1
//  rs2_id        in   5      decode-stage source register 2
//  use_rs1       in   1      decode instruction reads rs1
//  use_rs2       in   1      decode instruction reads rs2
//  opcode_ex     in   5      EX-stage opcode[6:2]; 5'b00000 = load
//  rd_ex         in   5      EX-stage destination register
//  rwben_ex      in   1      EX-stage register write-back enable
//  pcsel_ex      in   1      EX-stage taken branch/jump
//  mem_busy      in   1      data memory not ready; freeze whole pipeline
//  cnt_clr       in   1      synchronous clear of both counters
//  enb_1         out  2      IF/ID register enable code
//  enb_2         out  2      ID/EX register enable code
//  pc_en         out  1      PC register write enable
//  haz           out  1      1 when any code is not PASS
//  stall_cnt     out  CNT_W  cycles spent in load-use stall (saturating)
//  flush_cnt     out  CNT_W  cycles spent flushing (saturating)
// BEHAVIOUR
//  - Outputs enb_1/enb_2/pc_en/haz are combinational from state + inputs (zero-cycle latency).
//    State, down-counter and perf counters are registered.
//  - Reset: state=RUN, cnt=0, stall_cnt=0, flush_cnt=0. Outputs while reset is asserted:
//    enb_1=enb_2=BUBBLE, pc_en=0, haz=1.
//  - lu_hit = (opcode_ex==0) & rwben_ex & (rd_ex!=0)
//    & ((use_rs1 & rs1_id==rd_ex) | (use_rs2 & rs2_id==rd_ex)).
//  - Priority each cycle: mem_busy > branch > load-use > pass.
//  - mem_busy=1 in any state: enb_1=enb_2=HOLD, pc_en=0, haz=1. State, cnt and perf counters frozen.
//  - RUN, pcsel_ex=1:
//    - enb_1=enb_2=BUBBLE, pc_en=1 (target loads), flush_cnt+1.
//    - FLUSH_CYC>1: go FLUSH, cnt=FLUSH_CYC-1.
//  - RUN, lu_hit (no branch):
//    - enb_1=HOLD, enb_2=BUBBLE, pc_en=0, stall_cnt+1.
//    - LOAD_STALL_CYC>1: go LSTALL, cnt=LOAD_STALL_CYC-1.
//  - RUN otherwise: enb_1=enb_2=PASS, pc_en=1, haz=0.
//  - FLUSH: enb_1=enb_2=BUBBLE, pc_en=1, flush_cnt+1, cnt-1; cnt==1 -> RUN.
//    pcsel_ex ignored (EX holds a bubble).
//  - LSTALL: enb_1=HOLD, enb_2=BUBBLE, pc_en=0, stall_cnt+1, cnt-1; cnt==1 -> RUN.
//    pcsel_ex and lu_hit ignored.
//  - Bubbles leave rwben_ex=0 in EX, so no repeated stall after a completed load stall.
//  - Counters saturate at all-ones; cnt_clr wins over increment same cycle.
//  - Reset mid-FLUSH/LSTALL aborts to RUN immediately; counters cleared.
//  - rd_ex==0 never hazards. rs1 and rs2 both matching counts as one hazard.
// TESTING
//  1) lw x5 in EX, add x6,x5,x1 in ID (use_rs1=1)
//     -> 1 cycle enb_1=10, enb_2=00, pc_en=0; next cycle all PASS; stall_cnt=1.
//  2) Same with rd_ex=0 -> no stall, enb codes 01, haz=0.
//  3) pcsel_ex=1 with lu_hit=1 same cycle -> branch wins: enb_1=enb_2=00, pc_en=1, flush_cnt=1, stall_cnt=0.
//  4) FLUSH_CYC=3, pcsel_ex=1 -> three consecutive bubble cycles, pc_en=1 each, flush_cnt=3, then PASS.
//  5) mem_busy=1 for 4 cycles during LSTALL (LOAD_STALL_CYC=2)
//     -> codes 10/10, pc_en=0 for 4 cycles, then stall resumes 1 cycle; stall_cnt=2.
//  6) reset pulsed mid-FLUSH -> BUBBLE/pc_en=0 during reset; PASS after release; counters 0.
//     stall_cnt preset to all-ones + hazard -> stays all-ones.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline enable-code generator: load-use stalls, branch flushes and memory-busy freezes.
// Codes and pc_en are combinational (zero latency); state and counters are registered.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYC = 1,
  parameter int FLUSH_CYC      = 1,
  parameter int CNT_W          = 32
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [4:0]       opcode_ex,
  input  logic [4:0]       rd_ex,
  input  logic             rwben_ex,
  input  logic             pcsel_ex,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic [1:0]       enb_1,
  output logic [1:0]       enb_2,
  output logic             pc_en,
  output logic             haz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] EN_PASS   = 2'b01;
  localparam logic [1:0] EN_BUBBLE = 2'b00;
  localparam logic [1:0] EN_HOLD   = 2'b10;

  localparam int MAXC = (LOAD_STALL_CYC > FLUSH_CYC) ? LOAD_STALL_CYC : FLUSH_CYC;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_LSTALL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;
  logic             lu_hit;

  // rd_ex==0 is the hardwired zero register, so it can never carry a dependency.
  assign lu_hit = (opcode_ex == 5'b00000) && rwben_ex && (rd_ex != 5'd0) &&
                  ((use_rs1 && (rs1_id == rd_ex)) || (use_rs2 && (rs2_id == rd_ex)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enb_1     = EN_PASS;
    enb_2     = EN_PASS;
    pc_en     = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (reset) begin
      enb_1 = EN_BUBBLE;
      enb_2 = EN_BUBBLE;
      pc_en = 1'b0;
    end else if (mem_busy) begin
      enb_1 = EN_HOLD;
      enb_2 = EN_HOLD;
      pc_en = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pcsel_ex) begin
            enb_1     = EN_BUBBLE;
            enb_2     = EN_BUBBLE;
            flush_inc = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_d = ST_FLUSH;
              cnt_d   = CW'(FLUSH_CYC - 1);
            end
          end else if (lu_hit) begin
            enb_1     = EN_HOLD;
            enb_2     = EN_BUBBLE;
            pc_en     = 1'b0;
            stall_inc = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = ST_LSTALL;
              cnt_d   = CW'(LOAD_STALL_CYC - 1);
            end
          end
        end
        ST_FLUSH: begin
          enb_1     = EN_BUBBLE;
          enb_2     = EN_BUBBLE;
          flush_inc = 1'b1;
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_RUN;
        end
        ST_LSTALL: begin
          enb_1     = EN_HOLD;
          enb_2     = EN_BUBBLE;
          pc_en     = 1'b0;
          stall_inc = 1'b1;
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    haz = (enb_1 != EN_PASS) || (enb_2 != EN_PASS);
  end

  // Clear takes precedence over a same-cycle increment; increments stop at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: instance A (1/1 cycles, 3-bit counters) and instance B (2/3 cycles, 32-bit counters).
module tb_hazard_stall_ctrl;

  logic       cpu_clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_id, rs2_id, opcode_ex, rd_ex;
  logic       use_rs1, use_rs2, rwben_ex, pcsel_ex, mem_busy, cnt_clr;

  logic [1:0]  a_enb_1, a_enb_2, b_enb_1, b_enb_2;
  logic        a_pc_en, a_haz, b_pc_en, b_haz;
  logic [2:0]  a_stall_cnt, a_flush_cnt;
  logic [31:0] b_stall_cnt, b_flush_cnt;

  always #5 cpu_clk = ~cpu_clk;

  hazard_stall_ctrl #(.LOAD_STALL_CYC(1), .FLUSH_CYC(1), .CNT_W(3)) dut_a (
    .cpu_clk(cpu_clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .opcode_ex(opcode_ex), .rd_ex(rd_ex),
    .rwben_ex(rwben_ex), .pcsel_ex(pcsel_ex), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .enb_1(a_enb_1), .enb_2(a_enb_2), .pc_en(a_pc_en), .haz(a_haz),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  hazard_stall_ctrl #(.LOAD_STALL_CYC(2), .FLUSH_CYC(3), .CNT_W(32)) dut_b (
    .cpu_clk(cpu_clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .opcode_ex(opcode_ex), .rd_ex(rd_ex),
    .rwben_ex(rwben_ex), .pcsel_ex(pcsel_ex), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .enb_1(b_enb_1), .enb_2(b_enb_2), .pc_en(b_pc_en), .haz(b_haz),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  typedef struct packed {
    logic        sel_b;
    logic [1:0]  e1;
    logic [1:0]  e2;
    logic        pc;
    logic        hz;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic A = 1'b0;
  localparam logic B = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Push the expected outputs for the stimulus now applied, then pop and compare mid-cycle.
  task automatic cyc(input logic sel_b, input logic [1:0] e1, input logic [1:0] e2,
                     input logic pc, input logic hz, input int sc, input int fc);
    exp_t e;
    sb_q.push_back('{sel_b, e1, e2, pc, hz, 32'(sc), 32'(fc)});
    #2;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (e.sel_b) begin
        chk("B.enb_1", 32'(b_enb_1), 32'(e.e1));
        chk("B.enb_2", 32'(b_enb_2), 32'(e.e2));
        chk("B.pc_en", 32'(b_pc_en), 32'(e.pc));
        chk("B.haz", 32'(b_haz), 32'(e.hz));
        chk("B.stall_cnt", b_stall_cnt, e.sc);
        chk("B.flush_cnt", b_flush_cnt, e.fc);
      end else begin
        chk("A.enb_1", 32'(a_enb_1), 32'(e.e1));
        chk("A.enb_2", 32'(a_enb_2), 32'(e.e2));
        chk("A.pc_en", 32'(a_pc_en), 32'(e.pc));
        chk("A.haz", 32'(a_haz), 32'(e.hz));
        chk("A.stall_cnt", 32'(a_stall_cnt), e.sc);
        chk("A.flush_cnt", 32'(a_flush_cnt), e.fc);
      end
    end
    @(negedge cpu_clk);
  endtask

  task automatic set_idle();
    rs1_id = 5'd1; rs2_id = 5'd2; use_rs1 = 1'b0; use_rs2 = 1'b0;
    opcode_ex = 5'b01100; rd_ex = 5'd9; rwben_ex = 1'b1;
    pcsel_ex = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
  endtask

  // lw x<rd> in EX, add x6,x<rs>,x1 in ID reading rs1
  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs);
    opcode_ex = 5'b00000; rwben_ex = 1'b1; rd_ex = rd;
    rs1_id = rs; use_rs1 = 1'b1; rs2_id = 5'd1; use_rs2 = 1'b1;
  endtask

  task automatic do_reset(input logic sel_b);
    reset = 1'b1;
    set_idle();
    cyc(sel_b, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    @(negedge cpu_clk);

    // Load-use on rs1 -> one stall cycle, then PASS
    do_reset(A);
    set_lu(5'd5, 5'd5);
    cyc(A, 2'b10, 2'b00, 1'b0, 1'b1, 0, 0);
    set_idle();
    cyc(A, 2'b01, 2'b01, 1'b1, 1'b0, 1, 0);

    // rd_ex==0 never hazards
    set_lu(5'd0, 5'd0);
    cyc(A, 2'b01, 2'b01, 1'b1, 1'b0, 1, 0);
    // Match but rs not used / no write-back / not a load
    set_lu(5'd7, 5'd7); use_rs1 = 1'b0;
    cyc(A, 2'b01, 2'b01, 1'b1, 1'b0, 1, 0);
    set_lu(5'd7, 5'd7); rwben_ex = 1'b0;
    cyc(A, 2'b01, 2'b01, 1'b1, 1'b0, 1, 0);
    set_lu(5'd7, 5'd7); opcode_ex = 5'b00100;
    cyc(A, 2'b01, 2'b01, 1'b1, 1'b0, 1, 0);
    // rs2 match alone, then rs1+rs2 both matching counts once
    set_lu(5'd8, 5'd3); rs2_id = 5'd8;
    cyc(A, 2'b10, 2'b00, 1'b0, 1'b1, 1, 0);
    set_lu(5'd4, 5'd4); rs2_id = 5'd4;
    cyc(A, 2'b10, 2'b00, 1'b0, 1'b1, 2, 0);
    set_idle();
    cyc(A, 2'b01, 2'b01, 1'b1, 1'b0, 3, 0);

    // Branch beats load-use
    do_reset(A);
    set_lu(5'd5, 5'd5); pcsel_ex = 1'b1;
    cyc(A, 2'b00, 2'b00, 1'b1, 1'b1, 0, 0);
    set_idle();
    cyc(A, 2'b01, 2'b01, 1'b1, 1'b0, 0, 1);
    // mem_busy beats branch, counters frozen
    pcsel_ex = 1'b1; mem_busy = 1'b1;
    cyc(A, 2'b10, 2'b10, 1'b0, 1'b1, 0, 1);
    set_idle();
    cyc(A, 2'b01, 2'b01, 1'b1, 1'b0, 0, 1);

    // Three-cycle flush; pcsel_ex ignored while flushing
    do_reset(B);
    pcsel_ex = 1'b1;
    cyc(B, 2'b00, 2'b00, 1'b1, 1'b1, 0, 0);
    cyc(B, 2'b00, 2'b00, 1'b1, 1'b1, 0, 1);
    cyc(B, 2'b00, 2'b00, 1'b1, 1'b1, 0, 2);
    pcsel_ex = 1'b0;
    cyc(B, 2'b01, 2'b01, 1'b1, 1'b0, 0, 3);

    // mem_busy for 4 cycles in the middle of a 2-cycle load stall
    do_reset(B);
    set_lu(5'd5, 5'd5);
    cyc(B, 2'b10, 2'b00, 1'b0, 1'b1, 0, 0);
    set_idle(); mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) cyc(B, 2'b10, 2'b10, 1'b0, 1'b1, 1, 0);
    mem_busy = 1'b0;
    cyc(B, 2'b10, 2'b00, 1'b0, 1'b1, 1, 0);
    cyc(B, 2'b01, 2'b01, 1'b1, 1'b0, 2, 0);

    // Reset mid-flush aborts to RUN and clears counters
    do_reset(B);
    pcsel_ex = 1'b1;
    cyc(B, 2'b00, 2'b00, 1'b1, 1'b1, 0, 0);
    pcsel_ex = 1'b0;
    cyc(B, 2'b00, 2'b00, 1'b1, 1'b1, 0, 1);
    reset = 1'b1;
    cyc(B, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
    reset = 1'b0;
    cyc(B, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);

    // 3-bit stall counter saturates, then cnt_clr wins over increment
    do_reset(A);
    set_lu(5'd5, 5'd5);
    for (int i = 0; i < 7; i++) cyc(A, 2'b10, 2'b00, 1'b0, 1'b1, i, 0);
    cyc(A, 2'b10, 2'b00, 1'b0, 1'b1, 7, 0);
    cyc(A, 2'b10, 2'b00, 1'b0, 1'b1, 7, 0);
    cnt_clr = 1'b1;
    cyc(A, 2'b10, 2'b00, 1'b0, 1'b1, 7, 0);
    set_idle();
    cyc(A, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);

    if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
